// File: rtl/parity_rx_checker.sv
// parity_rx_checker: receiver for the 7-bit parity link.
// Deserialises start/D[6:0]/F/stop frames, flags parity and stop-bit errors, counts errors.
`default_nettype none

module parity_rx_checker #(
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             rx,
  input  logic             clr_cnt,
  output logic [6:0]       D_out,
  output logic             rx_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [2:0]       bit_cnt_q;
  logic [6:0]       shreg_q;
  logic [6:0]       shreg_d;
  logic             p_rx_q;
  logic             exp_par_q;
  logic [6:0]       D_out_q;
  logic             rx_valid_q;
  logic             parity_err_q;
  logic             frame_err_q;
  logic             busy_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic             w_parity_err;
  logic             w_frame_err;
  logic             w_err_event;

  always_comb begin
    shreg_d = shreg_q;
    for (int i = 0; i < 7; i++) begin
      if (bit_cnt_q == 3'(i)) begin
        shreg_d[i] = rx;
      end
    end
  end

  assign w_parity_err = (p_rx_q != exp_par_q);
  assign w_frame_err  = ~rx;
  assign w_err_event  = bit_en && (state_q == STOP) && (w_parity_err || w_frame_err);

  // Clear has priority over a coincident error event; the count never wraps.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (w_err_event && (err_cnt_q != C_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 7'd0;
      p_rx_q       <= 1'b0;
      exp_par_q    <= 1'b0;
      D_out_q      <= 7'd0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      err_cnt_q  <= err_cnt_d;
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!rx) begin
              state_q   <= DATA;
              bit_cnt_q <= 3'd0;
              busy_q    <= 1'b1;
            end
          end
          DATA: begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd6) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            p_rx_q    <= rx;
            exp_par_q <= (^shreg_q) ^ ODD_PARITY;
            state_q   <= STOP;
          end
          STOP: begin
            D_out_q      <= shreg_q;
            rx_valid_q   <= 1'b1;
            parity_err_q <= w_parity_err;
            frame_err_q  <= w_frame_err;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign D_out      = D_out_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign err_cnt    = err_cnt_q;

endmodule

`default_nettype wire
